// File: rtl/interrupt_sequencer.sv
// Prioritised interrupt sequencer: edge-latched requests, fixed priority (index 0 highest),
// jump-safe single-cycle interrupt pulse, vector/return-address capture, RETI retirement.
// Optional nested preemption with a return stack is enabled by defining IRQ_NESTING_EN.
//
// state     | meaning
// S_IDLE    | no routine active, waiting for an eligible source and no jump redirect
// S_FIRE    | one-cycle interrupt/ack pulse to jump control
// S_SERVICE | routine running, waiting for RETI (or preemption when nesting)
module interrupt_sequencer #(
  parameter int          NUM_SRC    = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0004,
  parameter logic [5:0]  RETI_OP    = 6'b011110,
  parameter int          NEST_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_irq_req,
  input  logic [NUM_SRC-1:0] i_irq_mask,
  input  logic [5:0]         i_op,
  input  logic               i_pc_mux_sel,
  input  logic [15:0]        i_current_address,
  output logic               o_interrupt,
  output logic [15:0]        o_vector_addr,
  output logic [15:0]        o_ret_addr,
  output logic [2:0]         o_irq_id,
  output logic [NUM_SRC-1:0] o_irq_ack,
  output logic               o_in_service
);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_SERVICE} state_t;

  state_t               r_state;
  logic [NUM_SRC-1:0]   r_req_d;
  logic [NUM_SRC-1:0]   r_pending;
  logic                 r_interrupt;
  logic [15:0]          r_vector_addr;
  logic [15:0]          r_ret_addr;
  logic [2:0]           r_irq_id;
  logic [NUM_SRC-1:0]   r_irq_ack;
  logic                 r_in_service;

  logic [NUM_SRC-1:0]   w_rise;
  logic [NUM_SRC-1:0]   w_elig;
  logic                 w_any;
  logic [2:0]           w_win_id;
  logic [NUM_SRC-1:0]   w_win_onehot;
  logic                 w_reti;

  function automatic logic [15:0] vec_of(input logic [2:0] id);
    return VEC_BASE + (16'(id) * VEC_STRIDE);
  endfunction

  assign w_rise       = i_irq_req & ~r_req_d;
  assign w_elig       = r_pending & ~i_irq_mask;
  assign w_any        = |w_elig;
  assign w_win_onehot = NUM_SRC'(1) << w_win_id;
  assign w_reti       = (i_op == RETI_OP);

  // Scan from the top so the lowest eligible index is the last (winning) assignment.
  always_comb begin
    w_win_id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_id = 3'(i);
    end
  end

  // A new edge in the same cycle as the ack re-arms the source.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_d   <= '0;
      r_pending <= '0;
    end else begin
      r_req_d   <= i_irq_req;
      r_pending <= (r_pending & ~r_irq_ack) | w_rise;
    end
  end

`ifdef IRQ_NESTING_EN
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

  logic [2:0]         r_stk_id   [NEST_DEPTH];
  logic [15:0]        r_stk_addr [NEST_DEPTH];
  logic [DEPTH_W-1:0] r_depth;
  logic               w_preempt;

  assign w_preempt = w_any && (w_win_id < r_irq_id) && !i_pc_mux_sel &&
                     (r_depth < DEPTH_W'(NEST_DEPTH));
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_interrupt   <= 1'b0;
      r_vector_addr <= VEC_BASE;
      r_ret_addr    <= 16'h0000;
      r_irq_id      <= 3'd0;
      r_irq_ack     <= '0;
      r_in_service  <= 1'b0;
`ifdef IRQ_NESTING_EN
      r_depth <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        r_stk_id[i]   <= 3'd0;
        r_stk_addr[i] <= 16'h0000;
      end
`endif
    end else begin
      r_interrupt <= 1'b0;
      r_irq_ack   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any && !i_pc_mux_sel) begin
            r_state       <= S_FIRE;
            r_irq_id      <= w_win_id;
            r_ret_addr    <= i_current_address;
            r_vector_addr <= vec_of(w_win_id);
            r_interrupt   <= 1'b1;
            r_irq_ack     <= w_win_onehot;
            r_in_service  <= 1'b1;
          end
        end
        S_FIRE: begin
          r_state <= S_SERVICE;
        end
        S_SERVICE: begin
          if (w_reti) begin
`ifdef IRQ_NESTING_EN
            if (r_depth != '0) begin
              r_irq_id      <= r_stk_id[0];
              r_ret_addr    <= r_stk_addr[0];
              r_vector_addr <= vec_of(r_stk_id[0]);
              r_depth       <= r_depth - 1'b1;
              for (int i = 0; i < NEST_DEPTH - 1; i++) begin
                r_stk_id[i]   <= r_stk_id[i+1];
                r_stk_addr[i] <= r_stk_addr[i+1];
              end
            end else begin
              r_state      <= S_IDLE;
              r_in_service <= 1'b0;
            end
`else
            r_state      <= S_IDLE;
            r_in_service <= 1'b0;
`endif
          end
`ifdef IRQ_NESTING_EN
          else if (w_preempt) begin
            for (int i = NEST_DEPTH - 1; i > 0; i--) begin
              r_stk_id[i]   <= r_stk_id[i-1];
              r_stk_addr[i] <= r_stk_addr[i-1];
            end
            r_stk_id[0]   <= r_irq_id;
            r_stk_addr[0] <= r_ret_addr;
            r_depth       <= r_depth + 1'b1;
            r_state       <= S_FIRE;
            r_irq_id      <= w_win_id;
            r_ret_addr    <= i_current_address;
            r_vector_addr <= vec_of(w_win_id);
            r_interrupt   <= 1'b1;
            r_irq_ack     <= w_win_onehot;
          end
`endif
        end
        default: begin
          r_state      <= S_IDLE;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  assign o_interrupt   = r_interrupt;
  assign o_vector_addr = r_vector_addr;
  assign o_ret_addr    = r_ret_addr;
  assign o_irq_id      = r_irq_id;
  assign o_irq_ack     = r_irq_ack;
  assign o_in_service  = r_in_service;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: vector table plus hand sequences,
// expected services queued at stimulus time and compared when the pulse appears.
module tb_interrupt_sequencer;

  localparam logic [5:0] RETI = 6'b011110;

  logic        clk;
  logic        rst_n;
  logic [3:0]  irq_req;
  logic [3:0]  irq_mask;
  logic [5:0]  op;
  logic        pc_mux_sel;
  logic [15:0] cur_addr;
  logic        o_interrupt;
  logic [15:0] o_vector_addr;
  logic [15:0] o_ret_addr;
  logic [2:0]  o_irq_id;
  logic [3:0]  o_irq_ack;
  logic        o_in_service;

  interrupt_sequencer dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_irq_req         (irq_req),
    .i_irq_mask        (irq_mask),
    .i_op              (op),
    .i_pc_mux_sel      (pc_mux_sel),
    .i_current_address (cur_addr),
    .o_interrupt       (o_interrupt),
    .o_vector_addr     (o_vector_addr),
    .o_ret_addr        (o_ret_addr),
    .o_irq_id          (o_irq_id),
    .o_irq_ack         (o_irq_ack),
    .o_in_service      (o_in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [2:0]  id;
    logic [15:0] vec;
    logic [3:0]  ack;
  } vec_t;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] vec;
    logic [3:0]  ack;
    logic [15:0] ret;
  } exp_t;

  vec_t tbl [4];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the pulse, compares it against the queue head, then retires with RETI.
  task automatic serve_one(input int max_wait, input bit reti_in_fire);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int n = 0; n < max_wait && !seen; n++) begin
      @(negedge clk);
      if (o_interrupt) seen = 1'b1;
    end
    chk("fire_within_bound", 32'(seen), 32'd1);
    if (!seen) return;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("irq_id", 32'(o_irq_id), 32'(e.id));
    chk("vector_addr", 32'(o_vector_addr), 32'(e.vec));
    chk("irq_ack", 32'(o_irq_ack), 32'(e.ack));
    chk("ret_addr", 32'(o_ret_addr), 32'(e.ret));
    chk("in_service_fire", 32'(o_in_service), 32'd1);
    if (reti_in_fire) op = RETI;
    @(negedge clk);
    op = 6'd0;
    chk("interrupt_one_cycle", 32'(o_interrupt), 32'd0);
    chk("ack_one_cycle", 32'(o_irq_ack), 32'd0);
    chk("in_service_service", 32'(o_in_service), 32'd1);
    op = RETI;
    @(negedge clk);
    op = 6'd0;
    chk("in_service_after_reti", 32'(o_in_service), 32'd0);
    chk("ret_addr_hold", 32'(o_ret_addr), 32'(e.ret));
  endtask

  initial begin
    bit got;
    tbl[0] = '{req: 4'b0100, mask: 4'b0000, addr: 16'h0012, id: 3'd2, vec: 16'h0048, ack: 4'b0100};
    tbl[1] = '{req: 4'b0001, mask: 4'b0000, addr: 16'h1234, id: 3'd0, vec: 16'h0040, ack: 4'b0001};
    tbl[2] = '{req: 4'b1000, mask: 4'b0111, addr: 16'hABCD, id: 3'd3, vec: 16'h004C, ack: 4'b1000};
    tbl[3] = '{req: 4'b0010, mask: 4'b1101, addr: 16'hFFFF, id: 3'd1, vec: 16'h0044, ack: 4'b0010};

    rst_n = 1'b0; irq_req = '0; irq_mask = '0; op = '0; pc_mux_sel = 1'b0; cur_addr = '0;
    #12;
    chk("rst_interrupt", 32'(o_interrupt), 32'd0);
    chk("rst_vector", 32'(o_vector_addr), 32'h0040);
    chk("rst_ret_addr", 32'(o_ret_addr), 32'h0000);
    chk("rst_irq_id", 32'(o_irq_id), 32'd0);
    chk("rst_ack", 32'(o_irq_ack), 32'd0);
    chk("rst_in_service", 32'(o_in_service), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      irq_req = tbl[k].req; irq_mask = tbl[k].mask; cur_addr = tbl[k].addr;
      sb.push_back('{id: tbl[k].id, vec: tbl[k].vec, ack: tbl[k].ack, ret: tbl[k].addr});
      serve_one(2, 1'b0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("no_refire_on_level", 32'(o_interrupt), 32'd0);
      end
      irq_req = '0; irq_mask = '0;
      @(negedge clk);
    end

    // Two simultaneous edges: source 1 first, RETI during FIRE ignored, then source 3.
    irq_req = 4'b1010; cur_addr = 16'h0100;
    sb.push_back('{id: 3'd1, vec: 16'h0044, ack: 4'b0010, ret: 16'h0100});
    sb.push_back('{id: 3'd3, vec: 16'h004C, ack: 4'b1000, ret: 16'h0100});
    serve_one(2, 1'b1);
    serve_one(3, 1'b0);
    irq_req = '0;
    @(negedge clk);

    // Jump redirect held for three decision edges defers the pulse.
    irq_req = 4'b0001; pc_mux_sel = 1'b1; cur_addr = 16'h0200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("deferred_no_pulse", 32'(o_interrupt), 32'd0);
    end
    pc_mux_sel = 1'b0; cur_addr = 16'h0300;
    sb.push_back('{id: 3'd0, vec: 16'h0040, ack: 4'b0001, ret: 16'h0300});
    serve_one(1, 1'b0);
    irq_req = '0;
    @(negedge clk);

    // Masked edge stays pending and fires once unmasked.
    irq_req = 4'b0100; irq_mask = 4'b0100; cur_addr = 16'h0400;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("masked_no_pulse", 32'(o_interrupt), 32'd0);
    end
    irq_mask = '0;
    sb.push_back('{id: 3'd2, vec: 16'h0048, ack: 4'b0100, ret: 16'h0400});
    serve_one(2, 1'b0);
    irq_req = '0;
    @(negedge clk);

`ifdef IRQ_NESTING_EN
    irq_req = 4'b1000; cur_addr = 16'h0500;
    got = 1'b0;
    for (int n = 0; n < 3 && !got; n++) begin
      @(negedge clk);
      if (o_interrupt) got = 1'b1;
    end
    chk("nest_outer_fire", 32'(got), 32'd1);
    @(negedge clk);
    irq_req = 4'b1001; cur_addr = 16'h0600;
    got = 1'b0;
    for (int n = 0; n < 3 && !got; n++) begin
      @(negedge clk);
      if (o_interrupt) got = 1'b1;
    end
    chk("nest_preempt_fire", 32'(got), 32'd1);
    chk("nest_preempt_id", 32'(o_irq_id), 32'd0);
    chk("nest_preempt_ack", 32'(o_irq_ack), 32'b0001);
    chk("nest_preempt_ret", 32'(o_ret_addr), 32'h0600);
    @(negedge clk);
    op = RETI;
    @(negedge clk);
    op = '0;
    chk("nest_pop_id", 32'(o_irq_id), 32'd3);
    chk("nest_pop_ret", 32'(o_ret_addr), 32'h0500);
    chk("nest_pop_vec", 32'(o_vector_addr), 32'h004C);
    chk("nest_pop_in_service", 32'(o_in_service), 32'd1);
    op = RETI;
    @(negedge clk);
    op = '0;
    chk("nest_final_in_service", 32'(o_in_service), 32'd0);
    irq_req = '0;
    @(negedge clk);
`endif

    // Asynchronous reset in the middle of servicing source 2.
    irq_req = 4'b0100; cur_addr = 16'h0077;
    got = 1'b0;
    for (int n = 0; n < 3 && !got; n++) begin
      @(negedge clk);
      if (o_interrupt) got = 1'b1;
    end
    chk("pre_reset_fire", 32'(got), 32'd1);
    @(negedge clk);
    chk("pre_reset_id", 32'(o_irq_id), 32'd2);
    chk("pre_reset_in_service", 32'(o_in_service), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_service", 32'(o_in_service), 32'd0);
    chk("async_rst_irq_id", 32'(o_irq_id), 32'd0);
    chk("async_rst_ret_addr", 32'(o_ret_addr), 32'h0000);
    chk("async_rst_vector", 32'(o_vector_addr), 32'h0040);
    chk("async_rst_interrupt", 32'(o_interrupt), 32'd0);
    chk("async_rst_ack", 32'(o_irq_ack), 32'd0);
    irq_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'(o_interrupt), 32'd0);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
